// File: rtl/word_port_sequencer.sv
// Purpose: host 8-bit window onto a 24-bit word port; stages bytes, commits whole words, reads coherent snapshots.
// Latency: commits and lane-0 data/direction reads take 2 cycles to hack, all other accesses take 1 cycle.
// Backpressure: hbusy is high while an access is in flight; strobes sampled while busy are dropped and flag err.
module word_port_sequencer (
  input  logic        clk,
  input  logic        clear,
  input  logic        hwr,
  input  logic        hrd,
  input  logic [2:0]  haddr,
  input  logic [7:0]  hdin,
  output logic [7:0]  hdout,
  output logic        hack,
  output logic        hbusy,
  output logic [23:0] port_ibus,
  output logic        port_loadport,
  output logic        port_loadddr,
  output logic        port_readddr,
  input  logic [23:0] port_obus,
  input  logic [23:0] pins_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_D  = 3'd1,
    S_LD_R  = 3'd2,
    S_RB_R  = 3'd3,
    S_CAP_D = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [23:0] r_stage_d;
  logic [23:0] r_stage_r;
  logic [23:0] r_snap;
  logic        r_err;
  logic [3:0]  r_ccnt;
  logic [23:0] r_sync1;
  logic [23:0] r_pins_s;
  logic [7:0]  r_hdout;

  // Host request decode. haddr[2] picks the direction side, haddr[1:0] the lane;
  // lane 3 on either side is the status register.
  logic        w_any;
  logic        w_accept;
  logic        w_err_set;
  logic        w_is_dir;
  logic [1:0]  w_lane;
  logic        w_status;
  logic        w_acc_wr;
  logic        w_acc_rd;

  assign w_any     = hwr | hrd;
  assign w_accept  = (r_state == S_IDLE) && (hwr ^ hrd);
  assign w_err_set = w_any && !w_accept;
  assign w_is_dir  = haddr[2];
  assign w_lane    = haddr[1:0];
  assign w_status  = (w_lane == 2'd3);
  assign w_acc_wr  = w_accept && hwr;
  assign w_acc_rd  = w_accept && hrd;

  // State register; clear forces IDLE immediately, which drops any strobe mid-cycle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: MS-lane writes commit through a load state, lane-0 reads
  // go through a capture state, everything else acknowledges directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_wr) begin
          if (w_lane == 2'd2) begin
            w_next = w_is_dir ? S_LD_R : S_LD_D;
          end else begin
            w_next = S_ACK;
          end
        end else if (w_acc_rd) begin
          if (w_lane == 2'd0) begin
            w_next = w_is_dir ? S_RB_R : S_CAP_D;
          end else begin
            w_next = S_ACK;
          end
        end
      end
      S_LD_D:  w_next = S_ACK;
      S_LD_R:  w_next = S_ACK;
      S_RB_R:  w_next = S_ACK;
      S_CAP_D: w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte staging for the data word; lanes persist across commits so an MS-only
  // rewrite recommits the previous low bytes.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_stage_d <= 24'h000000;
    end else if (w_acc_wr && !w_is_dir) begin
      case (w_lane)
        2'd0:    r_stage_d[7:0]   <= hdin;
        2'd1:    r_stage_d[15:8]  <= hdin;
        2'd2:    r_stage_d[23:16] <= hdin;
        default: r_stage_d        <= r_stage_d;
      endcase
    end
  end

  // Byte staging for the direction word, independent of the data word.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_stage_r <= 24'h000000;
    end else if (w_acc_wr && w_is_dir) begin
      case (w_lane)
        2'd0:    r_stage_r[7:0]   <= hdin;
        2'd1:    r_stage_r[15:8]  <= hdin;
        2'd2:    r_stage_r[23:16] <= hdin;
        default: r_stage_r        <= r_stage_r;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous pin levels.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sync1  <= 24'h000000;
      r_pins_s <= 24'h000000;
    end else begin
      r_sync1  <= pins_in;
      r_pins_s <= r_sync1;
    end
  end

  // Snapshot capture: the whole word is taken at once on a lane-0 read so the
  // later lane 1/2 reads see the same instant.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_snap <= 24'h000000;
    end else if (r_state == S_CAP_D) begin
      r_snap <= r_pins_s;
    end else if (r_state == S_RB_R) begin
      r_snap <= port_obus;
    end
  end

  // Read data register: loaded so that it is valid for the whole hack cycle and
  // then held until the next read completes.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_hdout <= 8'h00;
    end else if (r_state == S_CAP_D) begin
      r_hdout <= r_pins_s[7:0];
    end else if (r_state == S_RB_R) begin
      r_hdout <= port_obus[7:0];
    end else if (w_acc_rd) begin
      case (w_lane)
        2'd1:    r_hdout <= r_snap[15:8];
        2'd2:    r_hdout <= r_snap[23:16];
        2'd3:    r_hdout <= {r_ccnt, 3'b000, r_err};
        default: r_hdout <= r_hdout;
      endcase
    end
  end

  // Commit counter advances as each load state ends; a reset mid-load does not count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_ccnt <= 4'd0;
    end else if ((r_state == S_LD_D) || (r_state == S_LD_R)) begin
      r_ccnt <= r_ccnt + 4'd1;
    end
  end

  // Sticky error: set by dropped or colliding strobes, cleared only by writing 1
  // to status bit 0. Setting and clearing cannot coincide since a clear needs an accepted access.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_acc_wr && w_status && hdin[0]) begin
      r_err <= 1'b0;
    end
  end

  // Port-side outputs decoded purely from registered state; the bus is zero
  // except during a load so the port never sees a partially staged word.
  always_comb begin
    port_ibus = 24'h000000;
    case (r_state)
      S_LD_D:  port_ibus = r_stage_d;
      S_LD_R:  port_ibus = r_stage_r;
      default: port_ibus = 24'h000000;
    endcase
  end

  assign port_loadport = (r_state == S_LD_D);
  assign port_loadddr  = (r_state == S_LD_R);
  assign port_readddr  = (r_state == S_RB_R);
  assign hack          = (r_state == S_ACK);
  assign hbusy         = (r_state != S_IDLE);
  assign hdout         = r_hdout;

endmodule

// File: tb/tb_word_port_sequencer.sv
// Purpose: directed self-checking bench for word_port_sequencer.
// Latency: drives one host access at a time and measures cycles from sampling edge to hack.
// Backpressure: waits for hack plus the return to IDLE before issuing the next access.
module tb_word_port_sequencer;

  logic        clk;
  logic        clear;
  logic        hwr;
  logic        hrd;
  logic [2:0]  haddr;
  logic [7:0]  hdin;
  logic [7:0]  hdout;
  logic        hack;
  logic        hbusy;
  logic [23:0] port_ibus;
  logic        port_loadport;
  logic        port_loadddr;
  logic        port_readddr;
  logic [23:0] port_obus;
  logic [23:0] pins_in;

  int n_checks;
  int n_errors;

  word_port_sequencer dut (
    .clk          (clk),
    .clear        (clear),
    .hwr          (hwr),
    .hrd          (hrd),
    .haddr        (haddr),
    .hdin         (hdin),
    .hdout        (hdout),
    .hack         (hack),
    .hbusy        (hbusy),
    .port_ibus    (port_ibus),
    .port_loadport(port_loadport),
    .port_loadddr (port_loadddr),
    .port_readddr (port_readddr),
    .port_obus    (port_obus),
    .pins_in      (pins_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One host access. Returns read data, cycles to hack (-1 if none within budget),
  // strobe counts seen during the access and the port bus value while a load strobe was high.
  task automatic access(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat, output int nld,
                        output int nlr, output int nrb, output logic [23:0] ib);
    @(negedge clk);
    hwr = wr; hrd = ~wr; haddr = a; hdin = d;
    @(posedge clk);
    #1;
    hwr = 1'b0; hrd = 1'b0;
    rd = 8'h00; lat = -1; nld = 0; nlr = 0; nrb = 0; ib = 24'h0;
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      @(negedge clk);
      chk("strobe_excl", ($countones({port_loadport, port_loadddr, port_readddr}) <= 1), 1);
      if (port_loadport) begin nld++; ib = port_ibus; end
      if (port_loadddr)  begin nlr++; ib = port_ibus; end
      if (port_readddr)  nrb++;
      if (hack) begin lat = c; rd = hdout; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_simple(input logic [2:0] a, input logic [7:0] d, input string tag);
    logic [7:0] rd; int lat, nld, nlr, nrb; logic [23:0] ib;
    access(1'b1, a, d, rd, lat, nld, nlr, nrb, ib);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_nostrobe"}, nld + nlr + nrb, 0);
  endtask

  task automatic commit(input logic dir, input logic [7:0] d, input logic [23:0] exp_ib, input string tag);
    logic [7:0] rd; int lat, nld, nlr, nrb; logic [23:0] ib;
    access(1'b1, {dir, 2'd2}, d, rd, lat, nld, nlr, nrb, ib);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_nld"}, nld, dir ? 0 : 1);
    chk({tag, "_nlr"}, nlr, dir ? 1 : 0);
    chk({tag, "_ibus"}, ib, exp_ib);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input int exp_lat,
                        input int exp_nrb, input string tag);
    logic [7:0] rd; int lat, nld, nlr, nrb; logic [23:0] ib;
    access(1'b0, a, 8'h00, rd, lat, nld, nlr, nrb, ib);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_dat"}, rd, exp);
    chk({tag, "_nrb"}, nrb, exp_nrb);
  endtask

  initial begin
    int hacks;
    n_checks = 0; n_errors = 0;
    clear = 1'b1; hwr = 1'b0; hrd = 1'b0; haddr = 3'd0; hdin = 8'h00;
    port_obus = 24'h0; pins_in = 24'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hack", hack, 0);
    chk("rst_hbusy", hbusy, 0);
    chk("rst_ibus", port_ibus, 0);
    chk("rst_hdout", hdout, 0);
    chk("rst_strobes", {port_loadport, port_loadddr, port_readddr}, 0);
    clear = 1'b0;

    rd_chk(3'd3, 8'h00, 1, 0, "status0");

    // Direction word commit.
    wr_simple(3'd4, 8'h11, "wr4");
    wr_simple(3'd5, 8'h22, "wr5");
    commit(1'b1, 8'h33, 24'h332211, "commit_r");
    rd_chk(3'd7, 8'h10, 1, 0, "status1");

    // Data word commit.
    wr_simple(3'd0, 8'hAA, "wr0");
    wr_simple(3'd1, 8'hBB, "wr1");
    commit(1'b0, 8'hCC, 24'hCCBBAA, "commit_d");

    // Direction readback.
    port_obus = 24'h5A3C96;
    rd_chk(3'd4, 8'h96, 2, 1, "rdr4");
    rd_chk(3'd5, 8'h3C, 1, 0, "rdr5");
    rd_chk(3'd6, 8'h5A, 1, 0, "rdr6");

    // Coherent pin snapshot.
    @(negedge clk);
    pins_in = 24'h123456;
    repeat (3) @(posedge clk);
    rd_chk(3'd0, 8'h56, 2, 0, "rdp0");
    pins_in = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    rd_chk(3'd1, 8'h34, 1, 0, "rdp1");
    rd_chk(3'd2, 8'h12, 1, 0, "rdp2");

    // Write held into LD_D: second sample is dropped and flags err.
    @(negedge clk);
    hwr = 1'b1; hrd = 1'b0; haddr = 3'd2; hdin = 8'hDD;
    @(posedge clk);
    @(negedge clk);
    chk("busy_ld_d", port_loadport, 1);
    chk("busy_ibus", port_ibus, 24'hDDBBAA);
    @(posedge clk);
    #1;
    hwr = 1'b0;
    hacks = 0;
    repeat (4) begin
      @(negedge clk);
      if (hack) hacks++;
    end
    chk("busy_hacks", hacks, 1);

    // Colliding strobes in IDLE are dropped.
    @(negedge clk);
    hwr = 1'b1; hrd = 1'b1; haddr = 3'd0; hdin = 8'h00;
    @(posedge clk);
    #1;
    hwr = 1'b0; hrd = 1'b0;
    hacks = 0;
    repeat (3) begin
      @(negedge clk);
      if (hack || hbusy) hacks++;
    end
    chk("both_ignored", hacks, 0);
    rd_chk(3'd3, 8'h31, 1, 0, "status_err");
    wr_simple(3'd3, 8'h01, "errclr");
    rd_chk(3'd7, 8'h30, 1, 0, "status_clr");

    // Recommit reuses staged low bytes; thirteen more commits wrap ccnt 3 -> 0.
    commit(1'b1, 8'h44, 24'h442211, "recommit");
    for (int i = 0; i < 12; i++) commit(1'b1, 8'h44, 24'h442211, "wrap");
    rd_chk(3'd3, 8'h00, 1, 0, "status_wrap");

    // Put something nonzero into hdout, then clear in the middle of LD_R.
    rd_chk(3'd1, 8'h34, 1, 0, "pre_clr");
    @(negedge clk);
    hwr = 1'b1; hrd = 1'b0; haddr = 3'd6; hdin = 8'h55;
    @(posedge clk);
    #1;
    hwr = 1'b0;
    chk("ldr_on", port_loadddr, 1);
    chk("ldr_ibus", port_ibus, 24'h552211);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_ldr", port_loadddr, 0);
    chk("clr_ibus", port_ibus, 0);
    chk("clr_hbusy", hbusy, 0);
    chk("clr_hack", hack, 0);
    chk("clr_hdout", hdout, 0);
    @(negedge clk);
    clear = 1'b0;
    rd_chk(3'd1, 8'h00, 1, 0, "snap_clr");
    rd_chk(3'd3, 8'h00, 1, 0, "status_clr2");
    commit(1'b1, 8'h77, 24'h770000, "stage_clr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/word_port_sequencer.md
# word_port_sequencer

Host-side controller for one 24-bit bidirectional word port (data register, direction register, direction readback, pin drivers). It bridges the 8-bit host window to the 24-bit port. Byte writes are staged, and each 24-bit word is committed to the port with a single load strobe. Reads return byte lanes from a coherent 24-bit snapshot of either the synchronized pin levels or the direction register. A small state machine owns all port strobes, so the port is never loaded with a partially assembled word.

## Interface
Parameters:
- none (port width fixed at 24, host width fixed at 8)

Ports:
- clk  in  1  system clock; all state on rising edge
- clear  in  1  reset, asynchronous, active-high
- hwr  in  1  host write strobe, one cycle
- hrd  in  1  host read strobe, one cycle
- haddr  in  3  register select: 0/1/2 data lanes LS..MS, 4/5/6 direction lanes LS..MS, 3/7 status
- hdin  in  8  host write data
- hdout  out  8  host read data, registered, held until next read ack
- hack  out  1  one-cycle access-complete pulse
- hbusy  out  1  high whenever state is not IDLE
- port_ibus  out  24  word to port; stage_d in LD_D, stage_r in LD_R, else 24'h000000
- port_loadport  out  1  port data register load strobe
- port_loadddr  out  1  port direction register load strobe
- port_readddr  out  1  direction readback enable
- port_obus  in  24  direction readback bus, valid while port_readddr=1
- pins_in  in  24  raw pin levels, asynchronous

## Operation
- Registers:
  - stage_d[23:0] and stage_r[23:0]: independent staging words, so data and direction writes may interleave.
  - snap[23:0]: read snapshot.
  - err: sticky error bit.
  - ccnt[3:0]: commit counter.
  - 2-flop synchronizer on pins_in, producing pins_s.
- States: IDLE, LD_D, LD_R, RB_R, CAP_D, ACK.
- In IDLE, an access is accepted when exactly one of hwr/hrd is sampled high:
  - Write lane 0/1 (or 4/5): update that byte of stage_d (or stage_r); IDLE->ACK.
  - Write lane 2 (or 6): update MS byte; IDLE->LD_D (or LD_R)->ACK. The load strobe is high for the whole LD state, and port_ibus carries the full staged word. ccnt increments on leaving LD, wrapping 15->0.
  - Write addr 3/7: if hdin[0]=1, clear err; IDLE->ACK.
  - Read lane 0, data: IDLE->CAP_D (snap<=pins_s at end of CAP_D)->ACK; hdout<=snap[7:0]-equivalent byte in ACK.
  - Read lane 4, direction: IDLE->RB_R (port_readddr=1, snap<=port_obus at end of RB_R)->ACK; hdout<=byte 0.
  - Read lane 1/2 or 5/6: no recapture; IDLE->ACK; hdout<=snap byte 1/2. The software contract is to read lane 0 first.
  - Read addr 3/7: hdout<={ccnt, 3'b000, err}; IDLE->ACK.
- ACK->IDLE unconditionally; hack=1 only in ACK.
- Errors:
  - Any hwr/hrd sampled while not IDLE is ignored and sets err, with no hack.
  - hwr and hrd sampled high together are both ignored and set err.
- Staging words are not cleared by commit; a repeat MS-byte write recommits the same low bytes.

## Timing
- Reset: clear asserted forces IDLE immediately (asynchronous). All strobes, hack and hbusy go 0; port_ibus, hdout, stage_d, stage_r, snap, synchronizer, ccnt and err go 0.
- Reset mid-LD drops the strobe in the same cycle, with no partial commit guarantee beyond the port's own edge.
- Access sampled at edge E0:
  - Commit: load strobe high E0..E1, port captures at E1, hack high E1..E2.
  - Direction read lane 4: port_readddr high E0..E1, capture at E1, hack high E1..E2.
  - Data read lane 0: capture at E1, hack high E1..E2. Pin-to-snapshot latency is 2 synchronizer cycles plus capture.
  - All other accesses: hack high E0..E1.
- Next access is accepted at the first edge with state IDLE: E2 for 2-cycle accesses, E1 for 1-cycle accesses.
- At most one of port_loadport/port_loadddr/port_readddr is high in any cycle.
- All outputs are decoded from registered state; there is no combinational path from host inputs.

## Test plan
- Reset, then write 0x11/0x22/0x33 to addr 4/5/6: port_loadddr pulses once, port_ibus=0x332211 in that cycle, hack at E2, status read returns 0x10.
- Write 0xAA/0xBB to addr 0/1, then 0xCC to addr 2: port_loadport one cycle with 0xCCBBAA; no strobe on the lane 0/1 writes.
- With port_obus=0x5A3C96, read addr 4/5/6: port_readddr one cycle on the addr 4 read only; hdout 0x96, 0x3C, 0x5A.
- Set pins_in=0x123456, wait 3 cycles, read addr 0, change pins_in to 0xFFFFFF, read addr 1/2: hdout 0x56, 0x34, 0x12 (coherent snapshot).
- Issue hwr during LD_D, and hwr+hrd together in IDLE: both ignored, no hack, status bit0=1; write 0x01 to addr 3 clears it.
- Sixteen commits: ccnt wraps to 0. Assert clear during LD_R: strobe drops immediately, all outputs read 0.
